// File: rtl/fifo_protocol_checker_if.sv
// rtl/fifo_protocol_checker_if.sv - FIFO write/read handshake bundle observed by the protocol checker
interface fifo_protocol_checker_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  wfull;
  logic                  rinc;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rempty;

  // FIFO side: produces every handshake signal
  modport master (output winc, wdata, wfull, rinc, rdata, rempty);
  // Checker side: observes every handshake signal
  modport slave  (input  winc, wdata, wfull, rinc, rdata, rempty);
endinterface

// File: rtl/fifo_protocol_checker.sv
// rtl/fifo_protocol_checker.sv - shadow-model protocol checker for a synchronous FIFO
module fifo_protocol_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int READ_LAT   = 0,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       chk_en,
  input  logic                       clr_err,
  fifo_protocol_checker_if.slave     bus,
  output logic [6:0]                 err_flags,
  output logic                       err_any,
  output logic [CNT_W-1:0]           err_count,
  output logic                       first_err_vld,
  output logic [2:0]                 first_err,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [OW-1:0]    OCC_FULL = OW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Shadow FIFO state
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [AW-1:0]         rptr_q, rptr_d;
  logic [OW-1:0]         occ_q, occ_d;
  logic [DATA_WIDTH-1:0] rd_word;

  // Liveness state
  logic [TW-1:0]         stall_q, stall_d;
  logic [TW-1:0]         stall_run;
  logic                  stall_hit;

  // Error reporting state
  logic [6:0]            err_flags_q, err_flags_d;
  logic                  err_any_q;
  logic [CNT_W-1:0]      err_count_q, err_count_d;
  logic                  first_vld_q, first_vld_d;
  logic [2:0]            first_q, first_d;

  logic                  wr_acc, rd_acc;
  logic                  data_err;
  logic [6:0]            err_raw, err_now;
  logic [2:0]            first_idx;

  // Accept qualifiers: the occ guard keeps the shadow model from over/underflowing
  always_comb begin
    wr_acc  = bus.winc & ~bus.wfull & (occ_q != OCC_FULL);
    rd_acc  = bus.rinc & ~bus.rempty & (occ_q != '0);
    rd_word = mem_q[rptr_q];
    wptr_d  = wr_acc ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = rd_acc ? rptr_q + AW'(1) : rptr_q;
    occ_d   = occ_q + OW'(wr_acc) - OW'(rd_acc);
  end

  // Stall run length counts the current wfull cycle; it restarts after each hit
  always_comb begin
    stall_run = stall_q + TW'(1);
    stall_hit = 1'b0;
    stall_d   = '0;
    if (TIMEOUT != 0 && bus.wfull) begin
      if (stall_run == TW'(TIMEOUT)) begin
        stall_hit = 1'b1;
        stall_d   = '0;
      end else begin
        stall_d   = stall_run;
      end
    end
  end

  // Read data comparison, either against the current head or a one-cycle-old expectation
  generate
    if (READ_LAT == 0) begin : g_fwft
      assign data_err = rd_acc & (bus.rdata != rd_word);
    end else begin : g_lat1
      logic                  exp_vld_q;
      logic [DATA_WIDTH-1:0] exp_q;

      // Capture the expected word on each accepted read; reset discards in-flight expectations
      always_ff @(posedge clk) begin
        if (rst) begin
          exp_vld_q <= 1'b0;
          exp_q     <= '0;
        end else begin
          exp_vld_q <= rd_acc;
          exp_q     <= rd_word;
        end
      end

      assign data_err = exp_vld_q & (bus.rdata != exp_q);
    end
  endgenerate

  // Per-class error detection for this cycle, masked by chk_en
  always_comb begin
    err_raw[0] = bus.winc & bus.wfull;
    err_raw[1] = bus.rinc & bus.rempty;
    err_raw[2] = bus.wfull != (occ_q == OCC_FULL);
    err_raw[3] = bus.rempty != (occ_q == '0);
    err_raw[4] = data_err;
    err_raw[5] = bus.wfull & bus.rempty;
    err_raw[6] = stall_hit;
    err_now    = chk_en ? err_raw : '0;
    first_idx  = '0;
    for (int i = 6; i >= 0; i--) begin
      if (err_now[i]) first_idx = 3'(i);
    end
  end

  // Next-state for sticky flags, saturating counter and first-error capture
  always_comb begin
    err_flags_d = (err_flags_q & {7{~clr_err}}) | err_now;

    err_count_d = err_count_q;
    if (clr_err) begin
      err_count_d = (|err_now) ? CNT_W'(1) : '0;
    end else if ((|err_now) && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + CNT_W'(1);
    end

    first_vld_d = first_vld_q;
    first_d     = first_q;
    if (clr_err) begin
      first_vld_d = |err_now;
      first_d     = (|err_now) ? first_idx : 3'd0;
    end else if (!first_vld_q && (|err_now)) begin
      first_vld_d = 1'b1;
      first_d     = first_idx;
    end
  end

  // Shadow storage write; contents need no reset since occupancy gates every use
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem_q[wptr_q] <= bus.wdata;
    end
  end

  // Shadow pointers, occupancy and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      occ_q   <= '0;
      stall_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      occ_q   <= occ_d;
      stall_q <= stall_d;
    end
  end

  // Error reporting registers
  always_ff @(posedge clk) begin
    if (rst) begin
      err_flags_q <= '0;
      err_any_q   <= 1'b0;
      err_count_q <= '0;
      first_vld_q <= 1'b0;
      first_q     <= '0;
    end else begin
      err_flags_q <= err_flags_d;
      err_any_q   <= |err_flags_d;
      err_count_q <= err_count_d;
      first_vld_q <= first_vld_d;
      first_q     <= first_d;
    end
  end

  assign err_flags     = err_flags_q;
  assign err_any       = err_any_q;
  assign err_count     = err_count_q;
  assign first_err_vld = first_vld_q;
  assign first_err     = first_q;
  assign occupancy     = occ_q;

endmodule
